bus_ram: RTL
============

// Module: bus_ram
// PURPOSE
//  Word-wide synchronous RAM responder on the CPU memory bus (ready/addr/write_data/byte_enable/
//  write_req/read_req/read_data/read_data_valid). Answers the CPU's instruction fetches, loads
//  and stores. Occupies the program region at BASE_ADDR. Fixed read latency; pipelined,
//  in-order responses; byte-masked writes.
// PARAMETERS
//  ADDR_BITS     12            word-address bits; capacity = 4 << ADDR_BITS bytes (16 KiB)
//  BASE_ADDR     32'h10000000  byte address of word 0
//  READ_LATENCY  2             cycles from read acceptance to read_data_valid; legal 1..4
//  STALL_SEED    16'hace1      LFSR seed, used only with BUS_RAM_STALL_INJECT_EN
// PORTS
//  clk              in   1   clock
//  reset_n          in   1   asynchronous active-low reset
//  ready            out  1   responder can accept a request this cycle
//  addr             in   32  byte address; addr[1:0] ignored
//  write_data       in   32  store data
//  byte_enable      in   4   byte lane mask; bit i -> write_data[8i+7:8i]
//  write_req        in   1   store request
//  read_req         in   1   load/fetch request
//  read_data        out  32  read response data
//  read_data_valid  out  1   one-cycle pulse per accepted read
//  bus_error        out  1   sticky protocol/range error flag
// BEHAVIOUR
//  - Reset (async, reset_n low): ready=0, read_data=0, read_data_valid=0, bus_error=0.
//    In-flight reads are discarded. RAM contents are not cleared. On the first clk edge with
//    reset_n high, ready goes to 1.
//  - Acceptance: a request is accepted on a rising edge where ready && (read_req || write_req).
//    Requests presented while ready=0 are not accepted and carry no side effects.
//  - Range check: in range iff (addr - BASE_ADDR) < (4 << ADDR_BITS), using 32-bit unsigned
//    wrap arithmetic. Word index = (addr - BASE_ADDR) >> 2.
//  - Write: on acceptance, byte i of the indexed word is updated iff byte_enable[i].
//    byte_enable=0 is a legal no-op.
//  - Read: accepted at edge N. read_data_valid=1 with the word in the cycle following edge
//    N+READ_LATENCY-1, for exactly 1 cycle.
//    - One read may be accepted every cycle. Responses return in order, back-to-back.
//    - Pipeline depth = READ_LATENCY. There is no read backpressure.
//    - read_data holds its last value while read_data_valid=0.
//  - Read-after-write: a read accepted on the edge after a write to the same word returns
//    the new data.
//  - Out-of-range access: a write is dropped. A read still produces its read_data_valid pulse
//    with read_data=0. bus_error is set.
//  - read_req && write_req together: the write is performed, the read is dropped (no
//    response), and bus_error is set.
//  - bus_error is cleared only by reset.
//  - ready is a registered output. In the base build, ready=1 in every cycle after reset.
// CONFIGURATION
//  BUS_RAM_STALL_INJECT_EN defined:
//    - A 16-bit Galois LFSR (taps 16,14,13,11), seeded with STALL_SEED at reset, advances
//      every cycle.
//    - ready_next = 0 when lfsr[1:0]==2'b00, giving ~25% stall cycles.
//    - Exception: ready is never driven 0 in a cycle where a read is in flight or
//      read_data_valid=1. Initiators may sample read_data_valid only alongside ready.
//    - Latency, ordering and data are unchanged.
//  BUS_RAM_STALL_INJECT_EN undefined: no LFSR is built; ready is constant 1 after reset.
// TESTING
//  1. Reset release, no requests -> ready=1 one edge after reset_n high;
//     read_data_valid=0, bus_error=0.
//  2. Write 0x10000010 data 0xdeadbeef be=4'hf, then read 0x10000010 the next cycle
//     -> 0xdeadbeef valid exactly READ_LATENCY cycles after read acceptance.
//  3. Write 0x11223344 be=4'hf, then write 0x000000aa be=4'b0001 to the same word, then read
//     -> 0x112233aa.
//  4. Four back-to-back reads of words 0..3 holding 0,1,2,3 -> four consecutive
//     read_data_valid cycles carrying 0,1,2,3 in order.
//  5. Read 0x0ffffffc (below base) -> read_data_valid pulse with read_data=0 and bus_error=1.
//     A subsequent valid access leaves bus_error=1.
//  6. Assert reset_n=0 while 2 reads are in flight -> no read_data_valid after release;
//     previously written data is still readable.
//     With BUS_RAM_STALL_INJECT_EN: 1000 random reads and writes checked against a model;
//     ready is never 0 with a read in flight.

Source files
------------

// File: rtl/bus_ram.sv
// bus_ram: word-wide synchronous RAM responder with a fixed-latency, in-order read pipeline.
// Define BUS_RAM_STALL_INJECT_EN to add LFSR-driven pseudo-random ready stalls.
module bus_ram #(
    parameter int          ADDR_BITS    = 12,
    parameter logic [31:0] BASE_ADDR    = 32'h10000000,
    parameter int          READ_LATENCY = 2,
    parameter logic [15:0] STALL_SEED   = 16'hace1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        ready,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_enable,
    input  logic        write_req,
    input  logic        read_req,
    output logic [31:0] read_data,
    output logic        read_data_valid,
    output logic        bus_error
);

    localparam int          WORDS = 1 << ADDR_BITS;
    localparam logic [31:0] SPAN  = 32'(WORDS) << 2;

    logic [31:0]              mem [WORDS];
    logic [31:0]              offset;
    logic [ADDR_BITS-1:0]     wordIdx;
    logic                     inRange;
    logic                     reqAcc;
    logic                     wrAcc;
    logic                     rdAcc;
    logic                     errSet;
    logic [31:0]              rdWord;
    logic                     ready_q;
    logic                     ready_d;
    logic                     busError_q;
    logic [READ_LATENCY-1:0]  pipeValid_q;
    logic [31:0]              pipeData_q [READ_LATENCY];
    logic                     unusedOk;

    // Wrap-around subtraction makes addresses below the base land far out of range.
    always_comb begin
        offset  = addr - BASE_ADDR;
        inRange = offset < SPAN;
        wordIdx = offset[ADDR_BITS+1:2];
        reqAcc  = ready_q && (read_req || write_req);
        wrAcc   = reqAcc && write_req && inRange;
        rdAcc   = reqAcc && read_req && !write_req;
        errSet  = reqAcc && (!inRange || (read_req && write_req));
        rdWord  = inRange ? mem[wordIdx] : 32'h0;
    end

    assign unusedOk = ^{offset[1:0], STALL_SEED};

    always_ff @(posedge clk) begin
        if (wrAcc) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_enable[b]) begin
                    mem[wordIdx][8*b +: 8] <= write_data[8*b +: 8];
                end
            end
        end
    end

    // Data stages only load when a valid word moves in, so the output holds between responses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipeValid_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipeData_q[k] <= 32'h0;
            end
        end else begin
            pipeValid_q[0] <= rdAcc;
            if (rdAcc) begin
                pipeData_q[0] <= rdWord;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipeValid_q[k] <= pipeValid_q[k-1];
                if (pipeValid_q[k-1]) begin
                    pipeData_q[k] <= pipeData_q[k-1];
                end
            end
        end
    end

`ifdef BUS_RAM_STALL_INJECT_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        ready_d = (lfsr_q[1:0] != 2'b00) || rdAcc || (|pipeValid_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= STALL_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign ready_d = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q    <= 1'b0;
            busError_q <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            busError_q <= busError_q || errSet;
        end
    end

    assign ready           = ready_q;
    assign bus_error       = busError_q;
    assign read_data_valid = pipeValid_q[READ_LATENCY-1];
    assign read_data       = pipeData_q[READ_LATENCY-1];

endmodule
